fp16_add_aligner: RTL and testbench



---
 rtl/fp16_pkg.sv | 16 +
 rtl/fp16_add_aligner_if.sv | 38 +++
 rtl/fp16_unpack.sv | 21 ++
 rtl/fp16_add_aligner.sv | 124 ++++++++++++
 tb/tb_fp16_add_aligner.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/fp16_pkg.sv
// Shared widths and FSM state encoding for the FP16 add/sub alignment stage.
package fp16_pkg;

    localparam int unsigned FP_W      = 16;
    localparam int unsigned EXP_W     = 5;
    localparam int unsigned FRAC_W    = 10;
    localparam int unsigned MANT_W    = 11;
    localparam int unsigned ALIGN_SAT = 11;

    typedef enum logic [1:0] {
        IDLE,
        ALIGN,
        DONE
    } state_t;

endpackage

// File: rtl/fp16_add_aligner_if.sv
// Operand/result handshake bundle for fp16_add_aligner.
// The sticky signal exists only when FP16_ALIGN_STICKY_EN is defined.
interface fp16_add_aligner_if;
    import fp16_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [FP_W-1:0]   op_a;
    logic [FP_W-1:0]   op_b;
    logic              op_sub;
    logic              out_valid;
    logic              out_ready;
    logic              sign;
    logic [EXP_W-1:0]  exponent;
    logic [MANT_W-1:0] mant_big;
    logic [MANT_W-1:0] mant_small;
    logic              if_sub;
`ifdef FP16_ALIGN_STICKY_EN
    logic              sticky;
`endif

    modport slave (
        input  in_valid, op_a, op_b, op_sub, out_ready,
        output in_ready, out_valid, sign, exponent, mant_big, mant_small, if_sub
`ifdef FP16_ALIGN_STICKY_EN
        , output sticky
`endif
    );

    modport master (
        output in_valid, op_a, op_b, op_sub, out_ready,
        input  in_ready, out_valid, sign, exponent, mant_big, mant_small, if_sub
`ifdef FP16_ALIGN_STICKY_EN
        , input sticky
`endif
    );

endinterface

// File: rtl/fp16_unpack.sv
// Splits an FP16 word into sign, effective exponent and 11-bit mantissa with hidden bit.
module fp16_unpack
    import fp16_pkg::*;
(
    input  logic [FP_W-1:0]   word,
    output logic              sign,
    output logic [EXP_W-1:0]  exp_eff,
    output logic [MANT_W-1:0] mant
);

    logic [EXP_W-1:0] exp_raw;
    logic             hidden;

    // Denormals share exponent 1 with the smallest normals.
    assign exp_raw = word[FP_W-2 -: EXP_W];
    assign hidden  = |exp_raw;
    assign exp_eff = hidden ? exp_raw : EXP_W'(1);
    assign mant    = {hidden, word[FRAC_W-1:0]};
    assign sign    = word[FP_W-1];

endmodule

// File: rtl/fp16_add_aligner.sv
// FP16 pre-adder alignment: orders operands by magnitude and serially right-shifts
// the smaller mantissa. Optional sticky output under FP16_ALIGN_STICKY_EN.
module fp16_add_aligner
    import fp16_pkg::*;
#(
    parameter int unsigned SHIFT_STEP = 4
) (
    input logic               clk,
    input logic               rst,
    fp16_add_aligner_if.slave bus
);

    logic              sign_a, sign_b, sign_b_eff;
    logic [EXP_W-1:0]  exp_a, exp_b;
    logic [MANT_W-1:0] mant_a, mant_b;

    fp16_unpack u_unpack_a (.word(bus.op_a), .sign(sign_a), .exp_eff(exp_a), .mant(mant_a));
    fp16_unpack u_unpack_b (.word(bus.op_b), .sign(sign_b), .exp_eff(exp_b), .mant(mant_b));

    logic              a_big;
    logic              big_sign;
    logic [EXP_W-1:0]  big_exp, small_exp, diff;
    logic [MANT_W-1:0] big_mant, small_mant;

    // Magnitude order on {exp, frac}; ties keep A as the big operand.
    assign sign_b_eff = sign_b ^ bus.op_sub;
    assign a_big      = bus.op_a[FP_W-2:0] >= bus.op_b[FP_W-2:0];
    assign big_sign   = a_big ? sign_a : sign_b_eff;
    assign big_exp    = a_big ? exp_a  : exp_b;
    assign small_exp  = a_big ? exp_b  : exp_a;
    assign big_mant   = a_big ? mant_a : mant_b;
    assign small_mant = a_big ? mant_b : mant_a;
    assign diff       = big_exp - small_exp;

    state_t            state;
    logic [EXP_W-1:0]  remaining;
    logic [EXP_W-1:0]  step;
    logic              out_valid_q, sign_q, if_sub_q;
    logic [EXP_W-1:0]  exp_q;
    logic [MANT_W-1:0] mant_big_q, mant_small_q;

    assign step = (remaining < EXP_W'(SHIFT_STEP)) ? remaining : EXP_W'(SHIFT_STEP);

`ifdef FP16_ALIGN_STICKY_EN
    logic sticky_q;
    logic dropped;
    assign dropped = |(mant_small_q & ~(MANT_W'('1) << step));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            remaining    <= '0;
            out_valid_q  <= 1'b0;
            sign_q       <= 1'b0;
            if_sub_q     <= 1'b0;
            exp_q        <= '0;
            mant_big_q   <= '0;
            mant_small_q <= '0;
`ifdef FP16_ALIGN_STICKY_EN
            sticky_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sign_q     <= big_sign;
                        if_sub_q   <= sign_a ^ sign_b_eff;
                        exp_q      <= big_exp;
                        mant_big_q <= big_mant;
`ifdef FP16_ALIGN_STICKY_EN
                        sticky_q   <= 1'b0;
`endif
                        if (diff == '0) begin
                            mant_small_q <= small_mant;
                            state        <= DONE;
                        end else if (diff >= EXP_W'(ALIGN_SAT)) begin
                            // Shift would clear every bit: saturate in one step.
                            mant_small_q <= '0;
`ifdef FP16_ALIGN_STICKY_EN
                            sticky_q     <= |small_mant;
`endif
                            state        <= DONE;
                        end else begin
                            mant_small_q <= small_mant;
                            remaining    <= diff;
                            state        <= ALIGN;
                        end
                    end
                end
                ALIGN: begin
                    mant_small_q <= mant_small_q >> step;
`ifdef FP16_ALIGN_STICKY_EN
                    sticky_q     <= sticky_q | dropped;
`endif
                    remaining    <= remaining - step;
                    if (remaining == step) state <= DONE;
                end
                DONE: begin
                    // out_valid lags entry into DONE by one cycle.
                    if (out_valid_q && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        out_valid_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = (state == IDLE) && !rst;
    assign bus.out_valid  = out_valid_q;
    assign bus.sign       = sign_q;
    assign bus.exponent   = exp_q;
    assign bus.mant_big   = mant_big_q;
    assign bus.mant_small = mant_small_q;
    assign bus.if_sub     = if_sub_q;
`ifdef FP16_ALIGN_STICKY_EN
    assign bus.sticky     = sticky_q;
`endif

endmodule

// File: tb/tb_fp16_add_aligner.sv
// Directed self-checking bench for fp16_add_aligner (SHIFT_STEP = 4).
// Sticky checks are active when FP16_ALIGN_STICKY_EN is defined.
module tb_fp16_add_aligner;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    fp16_add_aligner_if bus ();

    fp16_add_aligner #(.SHIFT_STEP(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic sub);
        bus.op_a     = a;
        bus.op_b     = b;
        bus.op_sub   = sub;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_result(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({tag, ".idle_in_ready"}, 16'(bus.in_ready), 16'(1));
        chk({tag, ".idle_out_valid"}, 16'(bus.out_valid), 16'(0));
    endtask

    task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic sub, input logic e_sign, input logic [4:0] e_exp,
                       input logic [10:0] e_mb, input logic [10:0] e_ms, input logic e_if,
                       input logic e_st, input int e_lat);
        int lat;
        chk({tag, ".in_ready"}, 16'(bus.in_ready), 16'(1));
        send(a, b, sub);
        wait_valid(lat);
        chk({tag, ".latency"}, 16'(lat), 16'(e_lat));
        chk({tag, ".out_valid"}, 16'(bus.out_valid), 16'(1));
        chk({tag, ".sign"}, 16'(bus.sign), 16'(e_sign));
        chk({tag, ".exponent"}, 16'(bus.exponent), 16'(e_exp));
        chk({tag, ".mant_big"}, 16'(bus.mant_big), 16'(e_mb));
        chk({tag, ".mant_small"}, 16'(bus.mant_small), 16'(e_ms));
        chk({tag, ".if_sub"}, 16'(bus.if_sub), 16'(e_if));
`ifdef FP16_ALIGN_STICKY_EN
        chk({tag, ".sticky"}, 16'(bus.sticky), 16'(e_st));
`else
        if (e_st === 1'bx) $display("note: %s sticky expectation undefined", tag);
`endif
        release_result(tag);
    endtask

    initial begin
        int lat;
        errors        = 0;
        checks        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.op_sub    = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.out_valid", 16'(bus.out_valid), 16'(0));
        chk("reset.in_ready", 16'(bus.in_ready), 16'(0));
        chk("reset.mant_big", 16'(bus.mant_big), 16'(0));
        chk("reset.exponent", 16'(bus.exponent), 16'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        //   tag       a        b        sub   sign exp    mb       ms       if    st    lat
        run("d1",     16'h3C00, 16'h3800, 1'b0, 1'b0, 5'd15, 11'h400, 11'h200, 1'b0, 1'b0, 2);
        run("swap",   16'h3800, 16'h3C00, 1'b1, 1'b1, 5'd15, 11'h400, 11'h200, 1'b1, 1'b0, 2);
        run("d4",     16'h4C00, 16'h3C00, 1'b0, 1'b0, 5'd19, 11'h400, 11'h040, 1'b0, 1'b0, 2);
        run("d10",    16'h6400, 16'h3C00, 1'b0, 1'b0, 5'd25, 11'h400, 11'h001, 1'b0, 1'b0, 4);
        run("d11",    16'h6800, 16'h3C00, 1'b0, 1'b0, 5'd26, 11'h400, 11'h000, 1'b0, 1'b1, 1);
        run("d15",    16'h7800, 16'h3C00, 1'b0, 1'b0, 5'd30, 11'h400, 11'h000, 1'b0, 1'b1, 1);
        run("d0_bbig",16'h3C01, 16'h3C02, 1'b0, 1'b0, 5'd15, 11'h402, 11'h401, 1'b0, 1'b0, 1);
        run("tie",    16'h3C01, 16'h3C01, 1'b1, 1'b0, 5'd15, 11'h401, 11'h401, 1'b1, 1'b0, 1);
        run("denorm", 16'h0400, 16'h0001, 1'b0, 1'b0, 5'd1,  11'h400, 11'h001, 1'b0, 1'b0, 1);
        run("neg_d2", 16'hBC00, 16'h3400, 1'b0, 1'b1, 5'd15, 11'h400, 11'h100, 1'b1, 1'b0, 2);

        // Backpressure: result must hold while new operands are ignored.
        send(16'h3C00, 16'h3800, 1'b0);
        wait_valid(lat);
        chk("stall.latency", 16'(lat), 16'(2));
        for (int i = 0; i < 5; i++) begin
            bus.op_a     = 16'h7800;
            bus.op_b     = 16'h0001;
            bus.in_valid = 1'b1;
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            chk("stall.out_valid", 16'(bus.out_valid), 16'(1));
            chk("stall.in_ready", 16'(bus.in_ready), 16'(0));
            chk("stall.mant_small", 16'(bus.mant_small), 16'(11'h200));
            chk("stall.exponent", 16'(bus.exponent), 16'(15));
        end
        release_result("stall");

        // Reset in the middle of a long alignment abandons it.
        send(16'h6400, 16'h3C00, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst.out_valid", 16'(bus.out_valid), 16'(0));
        chk("midrst.in_ready", 16'(bus.in_ready), 16'(0));
        chk("midrst.mant_big", 16'(bus.mant_big), 16'(0));
        chk("midrst.mant_small", 16'(bus.mant_small), 16'(0));
        chk("midrst.exponent", 16'(bus.exponent), 16'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst.no_result", 16'(bus.out_valid), 16'(0));
        run("post_rst", 16'h3C00, 16'h3800, 1'b0, 1'b0, 5'd15, 11'h400, 11'h200, 1'b0, 1'b0, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
